// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back / memory-stage controller.
package wb_pkg;

  localparam int TIMEOUT_CYC_DEFAULT = 15;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_PC4 = 2'd1,
    WB_MEM = 2'd2,
    WB_CSR = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_WB       = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_controller_if.sv
// Execute-stage, data-memory and write-back signals seen by the controller.
interface wb_controller_if;

  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rd;
  logic        ex_reg_wr;
  logic [1:0]  ex_wb_sel;
  logic        ex_is_load;
  logic        ex_is_store;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;

  logic [1:0]  wb_sel;
  logic        reg_wr;
  logic [4:0]  wb_rd;
  logic        stall;
  logic        mem_err;

  modport slave (
    input  ex_valid, ex_rd, ex_reg_wr, ex_wb_sel, ex_is_load, ex_is_store,
    input  ex_addr, ex_wdata, dmem_ack,
    output ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output wb_sel, reg_wr, wb_rd, stall, mem_err
  );

  modport master (
    output ex_valid, ex_rd, ex_reg_wr, ex_wb_sel, ex_is_load, ex_is_store,
    output ex_addr, ex_wdata, dmem_ack,
    input  ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  wb_sel, reg_wr, wb_rd, stall, mem_err
  );

endinterface

// File: rtl/wb_controller_mem_timeout_ctr.sv
// Counts memory-wait cycles without acknowledge; expired marks the last allowed cycle.
module mem_timeout_ctr #(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/wb_controller.sv
// Write-back / data-memory controller: sequences ALU, load and store completion
// and stalls the pipeline while a memory access is outstanding.
module wb_controller
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input logic            clk,
  input logic            rst,
  wb_controller_if.slave bus
);

  wb_state_e   state_q;
  logic        dmem_req_q;
  logic        dmem_we_q;
  logic [31:0] dmem_addr_q;
  logic [31:0] dmem_wdata_q;
  wb_sel_e     wb_sel_q;
  logic        reg_wr_q;
  logic [4:0]  wb_rd_q;
  logic        stall_q;
  logic        mem_err_q;
  logic [4:0]  mem_rd_q;
  logic        mem_load_q;

  logic accept;
  logic is_mem;
  logic in_wait;
  logic expired;

  assign accept  = bus.ex_valid && !stall_q;
  assign is_mem  = bus.ex_is_load || bus.ex_is_store;
  assign in_wait = (state_q == ST_MEM_WAIT);

  mem_timeout_ctr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (accept && is_mem),
    .en_i     (in_wait && !bus.dmem_ack),
    .expired_o(expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      wb_sel_q     <= WB_ALU;
      reg_wr_q     <= 1'b0;
      wb_rd_q      <= '0;
      stall_q      <= 1'b0;
      mem_err_q    <= 1'b0;
      mem_rd_q     <= '0;
      mem_load_q   <= 1'b0;
    end else begin
      mem_err_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_WB: begin
          state_q  <= ST_IDLE;
          reg_wr_q <= 1'b0;
          stall_q  <= 1'b0;
          if (accept) begin
            if (is_mem) begin
              // A load flag takes precedence if both memory flags are set.
              state_q      <= ST_MEM_WAIT;
              stall_q      <= 1'b1;
              dmem_req_q   <= 1'b1;
              dmem_we_q    <= !bus.ex_is_load;
              dmem_addr_q  <= bus.ex_addr;
              dmem_wdata_q <= bus.ex_wdata;
              mem_rd_q     <= bus.ex_rd;
              mem_load_q   <= bus.ex_is_load;
            end else begin
              state_q  <= ST_WB;
              wb_sel_q <= wb_sel_e'(bus.ex_wb_sel);
              wb_rd_q  <= bus.ex_rd;
              reg_wr_q <= bus.ex_reg_wr && (bus.ex_rd != 5'd0);
            end
          end
        end
        ST_MEM_WAIT: begin
          // Acknowledge is checked first so it beats a same-cycle expiry.
          if (bus.dmem_ack) begin
            state_q    <= ST_WB;
            stall_q    <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            if (mem_load_q) begin
              wb_sel_q <= WB_MEM;
              wb_rd_q  <= mem_rd_q;
              reg_wr_q <= (mem_rd_q != 5'd0);
            end else begin
              reg_wr_q <= 1'b0;
            end
          end else if (expired) begin
            state_q    <= ST_IDLE;
            stall_q    <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            mem_err_q  <= 1'b1;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          stall_q  <= 1'b0;
          reg_wr_q <= 1'b0;
        end
      endcase
    end
  end

  // The request is withdrawn in the acknowledge cycle itself.
  assign bus.dmem_req   = dmem_req_q && !bus.dmem_ack;
  assign bus.dmem_we    = dmem_we_q;
  assign bus.dmem_addr  = dmem_addr_q;
  assign bus.dmem_wdata = dmem_wdata_q;
  assign bus.wb_sel     = wb_sel_q;
  assign bus.reg_wr     = reg_wr_q;
  assign bus.wb_rd      = wb_rd_q;
  assign bus.stall      = stall_q;
  assign bus.ex_ready   = !stall_q;
  assign bus.mem_err    = mem_err_q;

endmodule

// File: doc/wb_controller.md
WB_CONTROLLER -- requirements
Module: wb_controller

Interface
REQ-001 Parameter TIMEOUT_CYC, default 15: maximum dmem_req cycles without dmem_ack before abort; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 ex_valid  input  1  execute stage presents an instruction this cycle.
REQ-005 ex_ready  output  1  controller accepts ex_valid this cycle; equals !stall.
REQ-006 ex_rd  input  5  destination register index.
REQ-007 ex_reg_wr  input  1  instruction writes the register file.
REQ-008 ex_wb_sel  input  2  write-back source: 00 ALU, 01 PC+4, 10 load data, 11 CSR.
REQ-009 ex_is_load / ex_is_store  input  1 each  memory operation flags, mutually exclusive.
REQ-010 ex_addr / ex_wdata  input  32 each  memory address and store data.
REQ-011 dmem_req / dmem_we  output  1 each  memory request and write enable.
REQ-012 dmem_addr / dmem_wdata  output  32 each  registered request address and data.
REQ-013 dmem_ack  input  1  memory completion, one-cycle pulse.
REQ-014 wb_sel  output  2  select driven to the write-back mux.
REQ-015 reg_wr / wb_rd  output  1 / 5  register-file write enable and index.
REQ-016 stall  output  1  freezes fetch/decode/execute.
REQ-017 mem_err  output  1  one-cycle pulse on memory timeout.

Function
REQ-018 FSM states: IDLE, MEM_WAIT, WB. Accept means ex_valid && ex_ready.
REQ-019 Accept in IDLE or WB of a non-memory instruction: WB next cycle; wb_sel, wb_rd and reg_wr registered from inputs; reg_wr = ex_reg_wr && ex_rd != 0. Latency is 1 cycle, and back-to-back acceptance is allowed.
REQ-020 Accept of a load/store: go to MEM_WAIT next cycle; dmem_req=1; dmem_we=ex_is_store; address and data captured.
REQ-021 In MEM_WAIT: stall=1; dmem_req, dmem_we, dmem_addr and dmem_wdata held stable until dmem_ack.
REQ-022 dmem_ack in MEM_WAIT: dmem_req drops in the same cycle (combinationally) and the FSM goes to WB. A load writes back with wb_sel=10 and reg_wr=(rd!=0). A store gives reg_wr=0.
REQ-023 WB with no accept returns to IDLE; reg_wr=0 in IDLE and MEM_WAIT.
REQ-024 A timeout counter clears on entry to MEM_WAIT and increments each MEM_WAIT cycle without ack. When count reaches TIMEOUT_CYC-1 without ack: mem_err=1 for one cycle, dmem_req=0, no register write, go to IDLE.
REQ-025 dmem_ack on the same cycle as the final timeout count: ack wins and no mem_err is raised.
REQ-026 dmem_ack outside MEM_WAIT is ignored.
REQ-027 ex_is_load && ex_is_store both set: treated as load.
REQ-028 ex_valid while stall=1 is not accepted; the execute stage must hold its inputs.

Reset
REQ-029 rst=0 at a clock edge gives state IDLE and counter 0. Outputs reset to: dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, wb_sel=00, reg_wr=0, wb_rd=0, stall=0, mem_err=0.
REQ-030 Reset during MEM_WAIT abandons the request with no mem_err and no write; dmem_req is 0 on the first cycle after reset.

Structure
REQ-031 Shared package wb_pkg holds: wb_sel_e enum (WB_ALU=0, WB_PC4=1, WB_MEM=2, WB_CSR=3), wb_state_e enum, and the default TIMEOUT_CYC constant.
REQ-032 One sub-module, mem_timeout_ctr: clear/enable inputs, expired output, width $clog2(TIMEOUT_CYC+1).

Verification
REQ-033 Reset then three back-to-back ALU ops (rd=1,2,3, wb_sel=00) -> reg_wr=1 on cycles 1,2,3 after accept with wb_rd 1,2,3, and stall never asserted.
REQ-034 Load, rd=5, addr=0x100, ack after 3 cycles -> dmem_req high exactly 3 cycles, stall high during those cycles, then one WB cycle with wb_sel=10, wb_rd=5, reg_wr=1.
REQ-035 Store, addr=0x200, wdata=0xDEADBEEF, ack after 1 cycle -> dmem_we=1 and data stable, then reg_wr=0, then back to IDLE.
REQ-036 Load with no ack, TIMEOUT_CYC=4 -> mem_err pulses once, dmem_req low on the next cycle, no write, and a following ALU op completes normally.
REQ-037 JAL with rd=0 and wb_sel=01 -> wb_sel=01 with reg_wr=0.
REQ-038 rst=0 asserted in the 2nd MEM_WAIT cycle -> all outputs at reset values the next cycle, and a late ack is ignored.
